// File: rtl/contador_pkg.sv
// Shared constants for the contador counter family: direction encoding and
// the control-priority selector used by the next-state mux.
package contador_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        CTRL_CLEAR,
        CTRL_LOAD,
        CTRL_COUNT,
        CTRL_HOLD
    } ctrl_t;

endpackage

// File: rtl/contador_wrap_logic.sv
// Combinational next-count, wrap detection and cascade terminal count for a
// modulo-MODULUS up/down counter.
module contador_wrap_logic
    import contador_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic             enable,
    input  logic             load,
    input  logic             clear,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap,
    output logic             tc
);

    // One extra bit so MODULUS-1 and count+1 fit even when MODULUS = 2**WIDTH.
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] count_ext;

    always_comb begin
        count_ext  = {1'b0, count};
        wrap       = 1'b0;
        next_count = count;
        if (up == DIR_UP) begin
            wrap       = (count_ext == LAST);
            next_count = wrap ? '0 : WIDTH'(count_ext + 1'b1);
        end else begin
            wrap       = (count_ext == '0);
            next_count = wrap ? WIDTH'(LAST) : WIDTH'(count_ext - 1'b1);
        end
        tc = enable & ~load & ~clear & wrap;
    end

endmodule

// File: rtl/contador_mod_n_updown.sv
// Synchronous modulo-N up/down counter with enable, range-checked parallel
// load and cascadable terminal count / carry outputs.
module contador_mod_n_updown
    import contador_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input  logic             clk_input,
    input  logic             clear_input,
    input  logic             enable_input,
    input  logic             up_input,
    input  logic             load_input,
    input  logic [WIDTH-1:0] load_value_input,
    output logic [WIDTH-1:0] count_output,
    output logic             tc_output,
    output logic             carry_output,
    output logic             load_error_output
);

    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("contador_mod_n_updown: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    ctrl_t            ctrl;
    logic [WIDTH-1:0] next_count;
    logic             wrap;
    logic             load_valid;

    contador_wrap_logic #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_wrap (
        .count      (count_output),
        .up         (up_input),
        .enable     (enable_input),
        .load       (load_input),
        .clear      (clear_input),
        .next_count (next_count),
        .wrap       (wrap),
        .tc         (tc_output)
    );

    always_comb begin
        load_valid = ({1'b0, load_value_input} <= LAST);
        if (clear_input)
            ctrl = CTRL_CLEAR;
        else if (load_input)
            ctrl = CTRL_LOAD;
        else if (enable_input)
            ctrl = CTRL_COUNT;
        else
            ctrl = CTRL_HOLD;
    end

    // A rejected load leaves the count untouched and suppresses counting.
    always_ff @(posedge clk_input) begin
        case (ctrl)
            CTRL_CLEAR: begin
                count_output      <= '0;
                carry_output      <= 1'b0;
                load_error_output <= 1'b0;
            end
            CTRL_LOAD: begin
                if (load_valid)
                    count_output <= load_value_input;
                carry_output      <= 1'b0;
                load_error_output <= ~load_valid;
            end
            CTRL_COUNT: begin
                count_output      <= next_count;
                carry_output      <= wrap;
                load_error_output <= 1'b0;
            end
            default: begin
                carry_output      <= 1'b0;
                load_error_output <= 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_contador_mod_n_updown.sv
// Directed self-checking bench for contador_mod_n_updown: default-size,
// mod-10 and a cascaded mod-10 x mod-6 pair.
module tb_contador_mod_n_updown;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default parameters (WIDTH 5, MODULUS 32)
    logic       a_clear = 1'b1, a_enable = 1'b0, a_up = 1'b1, a_load = 1'b0;
    logic [4:0] a_load_value = '0;
    logic [4:0] a_count;
    logic       a_tc, a_carry, a_err;

    // WIDTH 4, MODULUS 10
    logic       b_clear = 1'b1, b_enable = 1'b0, b_up = 1'b1, b_load = 1'b0;
    logic [3:0] b_load_value = '0;
    logic [3:0] b_count;
    logic       b_tc, b_carry, b_err;

    // Cascade: low stage mod 10, high stage mod 6
    logic       c_clear = 1'b1, c_enable = 1'b0;
    logic [3:0] c_count;
    logic       c_tc, c_carry, c_err;
    logic [2:0] h_count;
    logic       h_tc, h_carry, h_err;

    contador_mod_n_updown dut_a (
        .clk_input(clk), .clear_input(a_clear), .enable_input(a_enable),
        .up_input(a_up), .load_input(a_load), .load_value_input(a_load_value),
        .count_output(a_count), .tc_output(a_tc), .carry_output(a_carry),
        .load_error_output(a_err)
    );

    contador_mod_n_updown #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk_input(clk), .clear_input(b_clear), .enable_input(b_enable),
        .up_input(b_up), .load_input(b_load), .load_value_input(b_load_value),
        .count_output(b_count), .tc_output(b_tc), .carry_output(b_carry),
        .load_error_output(b_err)
    );

    contador_mod_n_updown #(.WIDTH(4), .MODULUS(10)) dut_lo (
        .clk_input(clk), .clear_input(c_clear), .enable_input(c_enable),
        .up_input(1'b1), .load_input(1'b0), .load_value_input(4'd0),
        .count_output(c_count), .tc_output(c_tc), .carry_output(c_carry),
        .load_error_output(c_err)
    );

    contador_mod_n_updown #(.WIDTH(3), .MODULUS(6)) dut_hi (
        .clk_input(clk), .clear_input(c_clear), .enable_input(c_tc),
        .up_input(1'b1), .load_input(1'b0), .load_value_input(3'd0),
        .count_output(h_count), .tc_output(h_tc), .carry_output(h_carry),
        .load_error_output(h_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_clear = 1'b1; a_enable = 1'b1; a_up = 1'b0; a_load = 1'b0;
        tick();
        checks++;
        if (a_count !== 5'd0 || a_carry !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got count=%0d carry=%b err=%b expected 0/0/0", a_count, a_carry, a_err);
        end
        checks++;
        if (a_tc !== 1'b0) begin
            errors++;
            $display("FAIL tc_suppressed_by_clear: got %b expected 0", a_tc);
        end
        a_clear = 1'b0; a_enable = 1'b0; #1;
        a_enable = 1'b1; #1;
        checks++;
        if (a_tc !== 1'b1) begin
            errors++;
            $display("FAIL tc_down_at_zero: got %b expected 1", a_tc);
        end
        a_enable = 1'b0; a_up = 1'b1; #1;
    endtask

    task automatic test_wrap_up;
        int exp_count;
        a_clear = 1'b1; tick();
        a_clear = 1'b0; a_enable = 1'b1; a_up = 1'b1; #1;
        exp_count = 0;
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (a_tc !== (exp_count == 31)) begin
                errors++;
                $display("FAIL wrap_up_tc step %0d: got %b expected %b", i, a_tc, (exp_count == 31));
            end
            tick();
            checks++;
            if (a_count !== 5'(((exp_count + 1) % 32)) || a_carry !== (exp_count == 31)) begin
                errors++;
                $display("FAIL wrap_up_count step %0d: got count=%0d carry=%b expected %0d/%b",
                         i, a_count, a_carry, (exp_count + 1) % 32, (exp_count == 31));
            end
            exp_count = (exp_count + 1) % 32;
        end
        a_enable = 1'b0;
    endtask

    task automatic test_down_mod10;
        int exp_count;
        b_clear = 1'b1; tick();
        b_clear = 1'b0; b_enable = 1'b1; b_up = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (b_count !== 4'((exp_count == 0) ? 9 : exp_count - 1) || b_carry !== (exp_count == 0) ||
                b_count > 4'd9) begin
                errors++;
                $display("FAIL down_mod10 step %0d: got count=%0d carry=%b expected %0d/%b",
                         i, b_count, b_carry, (exp_count == 0) ? 9 : exp_count - 1, (exp_count == 0));
            end
            exp_count = (exp_count == 0) ? 9 : exp_count - 1;
        end
        b_enable = 1'b0;
    endtask

    task automatic test_load_range;
        b_clear = 1'b1; tick();
        b_clear = 1'b0; b_load = 1'b1; b_load_value = 4'd7;
        tick();
        checks++;
        if (b_count !== 4'd7 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL load_valid: got count=%0d err=%b expected 7/0", b_count, b_err);
        end
        b_load_value = 4'd12; b_enable = 1'b1; b_up = 1'b1;
        tick();
        checks++;
        if (b_count !== 4'd7 || b_err !== 1'b1 || b_carry !== 1'b0) begin
            errors++;
            $display("FAIL load_reject: got count=%0d err=%b carry=%b expected 7/1/0", b_count, b_err, b_carry);
        end
        b_load = 1'b0; b_enable = 1'b0;
        tick();
        checks++;
        if (b_count !== 4'd7 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL load_error_one_cycle: got count=%0d err=%b expected 7/0", b_count, b_err);
        end
        b_load = 1'b1; b_load_value = 4'd10;
        tick();
        checks++;
        if (b_count !== 4'd7 || b_err !== 1'b1) begin
            errors++;
            $display("FAIL load_boundary_10: got count=%0d err=%b expected 7/1", b_count, b_err);
        end
        b_load_value = 4'd9;
        tick();
        checks++;
        if (b_count !== 4'd9 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL load_boundary_9: got count=%0d err=%b expected 9/0", b_count, b_err);
        end
        b_load = 1'b0;
    endtask

    task automatic test_toggle;
        logic [4:0] exp_seq [4];
        exp_seq = '{5'd6, 5'd5, 5'd6, 5'd5};
        a_clear = 1'b1; tick();
        a_clear = 1'b0; a_enable = 1'b1; a_up = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (a_count !== 5'd5) begin
            errors++;
            $display("FAIL toggle_start: got %0d expected 5", a_count);
        end
        for (int i = 0; i < 4; i++) begin
            a_up = (i % 2 == 0);
            tick();
            checks++;
            if (a_count !== exp_seq[i] || a_carry !== 1'b0) begin
                errors++;
                $display("FAIL toggle step %0d: got count=%0d carry=%b expected %0d/0", i, a_count, a_carry, exp_seq[i]);
            end
        end
        a_enable = 1'b0; a_up = 1'b1;
    endtask

    task automatic test_load_over_terminal;
        a_clear = 1'b1; tick();
        a_clear = 1'b0; a_load = 1'b1; a_load_value = 5'd31;
        tick();
        a_load = 1'b0; a_enable = 1'b1; a_up = 1'b1; #1;
        checks++;
        if (a_tc !== 1'b1) begin
            errors++;
            $display("FAIL tc_at_31: got %b expected 1", a_tc);
        end
        a_load = 1'b1; a_load_value = 5'd3; #1;
        checks++;
        if (a_tc !== 1'b0) begin
            errors++;
            $display("FAIL tc_during_load: got %b expected 0", a_tc);
        end
        tick();
        checks++;
        if (a_count !== 5'd3 || a_carry !== 1'b0) begin
            errors++;
            $display("FAIL load_beats_enable: got count=%0d carry=%b expected 3/0", a_count, a_carry);
        end
        a_load = 1'b0; a_enable = 1'b0;
    endtask

    task automatic test_clear_priority;
        a_clear = 1'b0; a_load = 1'b1; a_load_value = 5'd17;
        tick();
        a_load_value = 5'd5; a_enable = 1'b1; a_up = 1'b1; a_clear = 1'b1;
        tick();
        checks++;
        if (a_count !== 5'd0 || a_carry !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: got count=%0d carry=%b err=%b expected 0/0/0", a_count, a_carry, a_err);
        end
        a_clear = 1'b0; a_load = 1'b0;
        tick();
        checks++;
        if (a_count !== 5'd1) begin
            errors++;
            $display("FAIL resume_after_clear: got %0d expected 1", a_count);
        end
        a_enable = 1'b0;
    endtask

    task automatic test_cascade;
        int combined;
        c_clear = 1'b1; tick();
        c_clear = 1'b0; c_enable = 1'b1;
        for (int n = 1; n <= 61; n++) begin
            tick();
            combined = int'(h_count) * 10 + int'(c_count);
            checks++;
            if (combined !== (n % 60) || c_count > 4'd9 || h_count > 3'd5) begin
                errors++;
                $display("FAIL cascade step %0d: got hi=%0d lo=%0d expected combined %0d", n, h_count, c_count, n % 60);
            end
        end
        c_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_wrap_up();
        test_down_mod10();
        test_load_range();
        test_toggle();
        test_load_over_terminal();
        test_clear_priority();
        test_cascade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
